// File: rtl/cnn_ofmap_reader.sv
// Captures one flattened CNN output fmap and streams it element by element over a valid/ready port.
// Optional build macro CNN_OFMAP_RELU_EN applies ReLU to each streamed element.
module cnn_ofmap_relu #(
  parameter int DATA_LEN = 8
) (
  input  logic [DATA_LEN-1:0] din,
  output logic [DATA_LEN-1:0] dout
);
`ifdef CNN_OFMAP_RELU_EN
  assign dout = din[DATA_LEN-1] ? '0 : din;
`else
  assign dout = din;
`endif
endmodule

module cnn_ofmap_reader #(
  parameter int DATA_LEN  = 8,
  parameter int NUM_WORDS = 36,
  localparam int IW = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_soft_reset,
  input  logic                          i_in_valid,
  input  logic [NUM_WORDS*DATA_LEN-1:0] i_in_fmap,
  input  logic                          i_ot_ready,
  output logic                          o_ot_valid,
  output logic [DATA_LEN-1:0]           o_ot_data,
  output logic [IW-1:0]                 o_ot_idx,
  output logic                          o_ot_last,
  output logic                          o_busy,
  output logic                          o_drop
);
  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  state_t                        state_q, state_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [NUM_WORDS*DATA_LEN-1:0] frame_q;
  logic                          drop_q, drop_d;
  logic                          cap, hs, is_last;
  logic [DATA_LEN-1:0]           elem_raw;

  assign hs      = (state_q == STREAM) && i_ot_ready;
  assign is_last = (idx_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
      if (i_soft_reset)
        frame_q <= '0;
      else if (cap)
        frame_q <= i_in_fmap;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap     = 1'b0;
    drop_d  = 1'b0;
    if (i_soft_reset) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_in_valid) begin
            cap     = 1'b1;
            state_d = STREAM;
            idx_d   = '0;
          end
        end
        STREAM: begin
          if (hs && is_last) begin
            // Final handshake frees the frame register, so a coincident pulse is accepted.
            idx_d   = '0;
            state_d = i_in_valid ? STREAM : IDLE;
            cap     = i_in_valid;
          end else begin
            if (hs) idx_d = idx_q + 1'b1;
            drop_d = i_in_valid;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign elem_raw = frame_q[idx_q*DATA_LEN +: DATA_LEN];

  cnn_ofmap_relu #(.DATA_LEN(DATA_LEN)) u_act (
    .din  (elem_raw),
    .dout (o_ot_data)
  );

  assign o_ot_valid = (state_q == STREAM);
  assign o_busy     = (state_q == STREAM);
  assign o_ot_idx   = idx_q;
  assign o_ot_last  = o_ot_valid && is_last;
  assign o_drop     = drop_q;
endmodule

// File: tb/tb_cnn_ofmap_reader.sv
// Directed bench for cnn_ofmap_reader with NUM_WORDS=4, DATA_LEN=8.
module tb_cnn_ofmap_reader;
  localparam int DL = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_soft_reset = 1'b0;
  logic          i_in_valid = 1'b0;
  logic [NW*DL-1:0] i_in_fmap = '0;
  logic          i_ot_ready = 1'b0;
  logic          o_ot_valid;
  logic [DL-1:0] o_ot_data;
  logic [1:0]    o_ot_idx;
  logic          o_ot_last;
  logic          o_busy;
  logic          o_drop;

  int n_cmp = 0;
  int n_bad = 0;

  cnn_ofmap_reader #(.DATA_LEN(DL), .NUM_WORDS(NW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_soft_reset (i_soft_reset),
    .i_in_valid   (i_in_valid),
    .i_in_fmap    (i_in_fmap),
    .i_ot_ready   (i_ot_ready),
    .o_ot_valid   (o_ot_valid),
    .o_ot_data    (o_ot_data),
    .o_ot_idx     (o_ot_idx),
    .o_ot_last    (o_ot_last),
    .o_busy       (o_busy),
    .o_drop       (o_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] i, input logic l, input logic b, input logic dr);
    chk({tag, ".valid"}, 32'(o_ot_valid), 32'(v));
    chk({tag, ".data"},  32'(o_ot_data),  32'(d));
    chk({tag, ".idx"},   32'(o_ot_idx),   32'(i));
    chk({tag, ".last"},  32'(o_ot_last),  32'(l));
    chk({tag, ".busy"},  32'(o_busy),     32'(b));
    chk({tag, ".drop"},  32'(o_drop),     32'(dr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [31:0] f);
    i_in_fmap  = f;
    i_in_valid = 1'b1;
    tick();
    i_in_valid = 1'b0;
  endtask

  logic [7:0] pat;
  logic [7:0] relu_exp [4];
  int k;

  initial begin
    // reset state
    #2;
    chk_out("rst", 0, 8'h00, 0, 0, 0, 0);
    #10 reset_n = 1'b1;
    tick();
    i_ot_ready = 1'b1;
    tick();
    chk_out("idle_ready", 0, 8'h00, 0, 0, 0, 0);

    // basic drain
    capture(32'h04030201);
    chk_out("drain0", 1, 8'h01, 0, 0, 1, 0);
    tick(); chk_out("drain1", 1, 8'h02, 1, 0, 1, 0);
    tick(); chk_out("drain2", 1, 8'h03, 2, 0, 1, 0);
    tick(); chk_out("drain3", 1, 8'h04, 3, 1, 1, 0);
    tick(); chk("drain_end.valid", 32'(o_ot_valid), 0);
    chk("drain_end.busy", 32'(o_busy), 0);

    // backpressure: ready pattern applied per cycle, LSB first
    pat = 8'b1010_1001;
    i_ot_ready = 1'b0;
    capture(32'h04030201);
    k = 0;
    for (int c = 0; c < 8; c++) begin
      i_ot_ready = pat[c];
      chk("bp.data", 32'(o_ot_data), 32'(k + 1));
      chk("bp.idx",  32'(o_ot_idx),  32'(k));
      chk("bp.last", 32'(o_ot_last), 32'(k == 3));
      tick();
      if (pat[c]) k++;
    end
    chk("bp_end.busy", 32'(o_busy), 0);
    chk("bp_end.count", 32'(k), 4);

    // overlap: rejected pulse mid-frame, accepted pulse on final handshake
    i_ot_ready = 1'b1;
    capture(32'h04030201);
    tick(); chk_out("ov1", 1, 8'h02, 1, 0, 1, 0);
    i_in_fmap = 32'hAABBCCDD; i_in_valid = 1'b1;
    tick(); i_in_valid = 1'b0;
    chk_out("ov2", 1, 8'h03, 2, 0, 1, 1);
    tick(); chk_out("ov3", 1, 8'h04, 3, 1, 1, 0);
    i_in_fmap = 32'h08070605; i_in_valid = 1'b1;
    tick(); i_in_valid = 1'b0;
    chk_out("b2b0", 1, 8'h05, 0, 0, 1, 0);
    tick(); chk_out("b2b1", 1, 8'h06, 1, 0, 1, 0);
    tick(); chk_out("b2b2", 1, 8'h07, 2, 0, 1, 0);
    tick(); chk_out("b2b3", 1, 8'h08, 3, 1, 1, 0);
    tick(); chk_out("b2b_end", 0, 8'h05, 0, 0, 0, 0);

    // async reset mid-frame
    capture(32'h04030201);
    tick(); tick();
    chk("pre_rst.idx", 32'(o_ot_idx), 2);
    #1 reset_n = 1'b0;
    #1 chk_out("arst", 0, 8'h00, 0, 0, 0, 0);
    #1 reset_n = 1'b1;
    tick(); chk_out("arst_hold", 0, 8'h00, 0, 0, 0, 0);

    // soft reset mid-frame, then restart
    capture(32'h04030201);
    tick(); chk("pre_srst.idx", 32'(o_ot_idx), 1);
    i_soft_reset = 1'b1;
    tick(); i_soft_reset = 1'b0;
    chk_out("srst", 0, 8'h00, 0, 0, 0, 0);
    tick(); chk_out("srst_hold", 0, 8'h00, 0, 0, 0, 0);
    capture(32'h04030201);
    chk_out("restart", 1, 8'h01, 0, 0, 1, 0);
    tick(); tick(); tick(); tick();

    // activation
`ifdef CNN_OFMAP_RELU_EN
    relu_exp = '{8'h00, 8'h00, 8'h00, 8'h7F};
`else
    relu_exp = '{8'h80, 8'hFF, 8'h00, 8'h7F};
`endif
    capture(32'h7F00FF80);
    for (int j = 0; j < 4; j++) begin
      chk("act.data", 32'(o_ot_data), 32'(relu_exp[j]));
      tick();
    end
    chk("act_end.busy", 32'(o_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cnn_ofmap_reader.md
CNN_OFMAP_READER -- requirements
Module: cnn_ofmap_reader

Interface
REQ-001 Parameter DATA_LEN, default 8, bit width of one fmap element.
REQ-002 Parameter NUM_WORDS, default 36, element count of the captured fmap (IN*OCH*OX*OY); legal range is NUM_WORDS >= 2.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_soft_reset  input  1  synchronous clear, active-high.
REQ-006 i_in_valid  input  1  one-cycle pulse from the conv top core marking a fresh output fmap.
REQ-007 i_in_fmap  input  NUM_WORDS*DATA_LEN  flattened output fmap; element k occupies bits [k*DATA_LEN +: DATA_LEN].
REQ-008 i_ot_ready  input  1  downstream sink ready.
REQ-009 o_ot_valid  output  1  o_ot_data holds a valid element.
REQ-010 o_ot_data  output  DATA_LEN  current element.
REQ-011 o_ot_idx  output  max(1,clog2(NUM_WORDS))  index k of the current element.
REQ-012 o_ot_last  output  1  current element is k = NUM_WORDS-1.
REQ-013 o_busy  output  1  a frame is held and not yet fully drained.
REQ-014 o_drop  output  1  one-cycle pulse: an i_in_valid pulse was rejected.

Function
REQ-015 The FSM SHALL have two states: IDLE (no frame held) and STREAM (frame held, draining).
REQ-016 In IDLE, i_in_valid=1 SHALL latch i_in_fmap into an internal frame register, clear the index to 0, and enter STREAM on the same edge.
REQ-017 o_ot_valid SHALL be 1 in STREAM and 0 in IDLE, so the first element is presented the cycle after the capture edge.
REQ-018 o_ot_data SHALL equal element o_ot_idx of the latched frame, driven from registers or a mux of registered state only, with no combinational path from i_in_fmap.
REQ-019 A handshake is o_ot_valid & i_ot_ready; on a handshake with idx < NUM_WORDS-1 the index SHALL increment by 1.
REQ-020 Without a handshake, o_ot_data, o_ot_idx and o_ot_last SHALL hold stable.
REQ-021 On the handshake at idx = NUM_WORDS-1, the FSM SHALL return to IDLE and the index SHALL reset to 0.
REQ-022 If i_in_valid=1 in the same cycle as that final handshake, the new frame SHALL be captured and STREAM re-entered with idx=0 (zero-bubble back-to-back), and o_drop SHALL stay 0.
REQ-023 If i_in_valid=1 in STREAM at any other time, the pulse SHALL be ignored, the held frame SHALL be unaffected, and o_drop SHALL pulse 1 on the next cycle.
REQ-024 o_busy SHALL equal (state == STREAM).
REQ-025 i_ot_ready in IDLE SHALL have no effect.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state=IDLE, idx=0, frame register=0, o_ot_valid=0, o_ot_data=0, o_ot_last=0, o_busy=0 and o_drop=0.
REQ-027 i_soft_reset=1 SHALL produce the same values on the next edge, taking priority over capture and handshake.
REQ-028 A reset asserted mid-frame SHALL discard the remaining elements, and no further element SHALL be presented until a new capture.

Configuration
REQ-029 With macro CNN_OFMAP_RELU_EN defined, o_ot_data SHALL be ReLU(element): elements are treated as two's-complement signed, negative values output as 0 and non-negative values passed unchanged.
REQ-030 With CNN_OFMAP_RELU_EN undefined, o_ot_data SHALL be the raw latched element bit-for-bit (no activation).
REQ-031 The macro SHALL affect only o_ot_data values; all timing, handshake and control behaviour SHALL be identical in both builds.

Verification
REQ-032 Basic drain: with NUM_WORDS=4, DATA_LEN=8, i_in_fmap=0x04030201, a 1-cycle i_in_valid and i_ot_ready held 1 -> data 01,02,03,04 on four consecutive cycles, idx 0..3, o_ot_last only with 04, then o_busy=0.
REQ-033 Backpressure: same frame with i_ot_ready toggling 1,0,0,1,... -> each element held stable while ready=0, no element skipped or duplicated.
REQ-034 Overlap: i_in_valid pulsed again at idx=1 with a different fmap -> that fmap is ignored, o_drop pulses once, original elements 03,04 still follow; i_in_valid on the final handshake with fmap 0x08070605 -> 05 is presented the next cycle and o_drop stays 0.
REQ-035 Reset mid-frame: reset_n pulsed low at idx=2 -> all outputs are 0 immediately; i_soft_reset at idx=1 -> outputs are 0 next cycle; a subsequent capture restarts from idx=0.
REQ-036 ReLU: fmap elements 0x80,0xFF,0x00,0x7F -> with CNN_OFMAP_RELU_EN output 00,00,00,7F; without the macro output 80,FF,00,7F.
